// File: rtl/transmitter_if.sv
// ---------------------------------------------------------------------------
// transmitter_if
//   Bundles the request-side handshake and the packet-launch bus of one
//   network node's transmitter.
//
//   send_req   : request to enqueue (send_dest, send_data)
//   send_dest  : destination node ID
//   send_data  : payload
//   send_ready : queue can accept; a request is taken when send_req && send_ready
//   tx_out     : packet {src_id, data, dest_id}; zero when not transmitting
//   tx_valid   : tx_out carries a packet this cycle
//
//   master : the node-local logic issuing requests and observing the bus
//   slave  : the transmitter itself
// ---------------------------------------------------------------------------
interface transmitter_if #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 1
);
    logic                              send_req;
    logic [ID_WIDTH-1:0]               send_dest;
    logic [DATA_WIDTH-1:0]             send_data;
    logic                              send_ready;
    logic [2*ID_WIDTH+DATA_WIDTH-1:0]  tx_out;
    logic                              tx_valid;

    modport master (
        output send_req, send_dest, send_data,
        input  send_ready, tx_out, tx_valid
    );

    modport slave (
        input  send_req, send_dest, send_data,
        output send_ready, tx_out, tx_valid
    );
endinterface

// File: rtl/transmitter.sv
// ---------------------------------------------------------------------------
// transmitter
//   Queues (destination, data) requests in a small circular FIFO and launches
//   one packet per TDM round, in the slot this node owns (slot_cnt == id).
//   The emitted packet is {id, data, dest} and is held for exactly one cycle;
//   tx_out is forced to zero otherwise because the interconnect ORs all
//   nodes' tx_out together.
//
//   Ports:
//     clk        : system clock, all state on the rising edge
//     rst        : synchronous active-high reset
//     id         : this node's ID (static after reset)
//     bus        : transmitter_if.slave (send_req/dest/data/ready, tx_out/valid)
//     slot_cnt   : current TDM slot, 0 .. NUM_NODES-1
//     fifo_count : number of queued requests
//
//   Optional feature macro: TX_DROP_SELF_EN
//     When defined, accepted requests addressed to this node's own id are
//     discarded instead of queued.
// ---------------------------------------------------------------------------
module transmitter #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 1,
    parameter int NUM_NODES  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ID_WIDTH-1:0]        id,
    transmitter_if.slave               bus,
    output logic [ID_WIDTH-1:0]        slot_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + ID_WIDTH;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SLOT = 2'd1;
    localparam logic [1:0] ST_SEND      = 2'd2;

    localparam logic [ID_WIDTH-1:0] LAST_SLOT = ID_WIDTH'(NUM_NODES - 1);
    localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(FIFO_DEPTH);

    // ---------------- registers ----------------
    logic [ID_WIDTH-1:0]              r_slot_cnt;
    logic [1:0]                       r_state;
    logic [ENT_W-1:0]                 r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                 r_wr_ptr;
    logic [PTR_W-1:0]                 r_rd_ptr;
    logic [CNT_W-1:0]                 r_count;
    logic                             r_send_ready;
    logic                             r_tx_valid;
    logic [2*ID_WIDTH+DATA_WIDTH-1:0] r_tx_out;

    // ---------------- combinational ----------------
    logic             w_drop;
    logic             w_push;
    logic             w_grant;
    logic [CNT_W-1:0] w_count_next;
    logic [1:0]       w_state_next;
    logic [ENT_W-1:0] w_head;

`ifdef TX_DROP_SELF_EN
    assign w_drop = (bus.send_dest == id);
`else
    assign w_drop = 1'b0;
`endif

    // send_ready is the registered "not full", so a request arriving while
    // full is rejected even if the same cycle pops an entry.
    assign w_push  = bus.send_req && r_send_ready && !w_drop;
    // Being in WAIT_SLOT guarantees the queue is nonempty; an entry pushed
    // in the owned slot itself is therefore not eligible until next round.
    assign w_grant = (r_state == ST_WAIT_SLOT) && (r_slot_cnt == id);
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_grant})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_count_next != '0) w_state_next = ST_WAIT_SLOT;
            ST_WAIT_SLOT: if (w_grant)            w_state_next = ST_SEND;
            ST_SEND:      w_state_next = (w_count_next != '0) ? ST_WAIT_SLOT : ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- TDM slot counter ----------------
    always_ff @(posedge clk) begin
        if (rst)
            r_slot_cnt <= '0;
        else if (r_slot_cnt == LAST_SLOT)
            r_slot_cnt <= '0;
        else
            r_slot_cnt <= r_slot_cnt + 1'b1;
    end

    // ---------------- queue storage (no reset: RAM-style) ----------------
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {bus.send_data, bus.send_dest};
    end

    // ---------------- queue control + FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_send_ready <= 1'b1;
            r_state      <= ST_IDLE;
        end else begin
            // Depth is a power of two, so the pointers wrap naturally.
            if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_grant) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count      <= w_count_next;
            r_send_ready <= (w_count_next != FULL_CNT);
            r_state      <= w_state_next;
        end
    end

    // ---------------- packet launch register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_out   <= '0;
        end else if (w_grant) begin
            r_tx_valid <= 1'b1;
            r_tx_out   <= {id, w_head};
        end else begin
            r_tx_valid <= 1'b0;
            r_tx_out   <= '0;
        end
    end

    assign bus.send_ready = r_send_ready;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.tx_out     = r_tx_out;
    assign slot_cnt       = r_slot_cnt;
    assign fifo_count     = r_count;

endmodule

// File: tb/tb_transmitter.sv
// ---------------------------------------------------------------------------
// tb_transmitter
//   Directed scenarios for the node transmitter (ID_WIDTH=2, DATA_WIDTH=8,
//   NUM_NODES=4, FIFO_DEPTH=4, id=2). A queue-based model tracks the request
//   queue and the round position and is compared against every output on
//   every falling edge; hand-computed literals pin key points of the model.
// ---------------------------------------------------------------------------
module tb_transmitter;
    localparam int IW = 2;
    localparam int DW = 8;
    localparam int NN = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] id  = 2'd2;
    logic [IW-1:0] slot_cnt;
    logic [2:0]    fifo_count;

    transmitter_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

    transmitter #(
        .ID_WIDTH(IW), .DATA_WIDTH(DW), .NUM_NODES(NN), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .id(id), .bus(bus),
        .slot_cnt(slot_cnt), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Rules: the slot advances every cycle mod NN; in a cycle whose slot is
    // id and whose queue (as it stood at the start of the cycle) is nonempty,
    // the head is sent during the following cycle; a request is taken when
    // the queue held fewer than FD entries at the start of the cycle.
    int          m_slot;
    logic [9:0]  m_q[$];
    logic        m_valid;
    logic [11:0] m_out;
    bit          cmp_en = 0;

    initial begin : model
        int          sz;
        bit          acc;
        logic [9:0]  e;
        logic        nv;
        logic [11:0] no;
        m_slot = 0; m_valid = 1'b0; m_out = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_slot = 0; m_q.delete(); m_valid = 1'b0; m_out = '0;
            end else begin
                sz = m_q.size();
                nv = 1'b0; no = '0;
                if (m_slot == int'(id) && sz > 0) begin
                    e  = m_q.pop_front();
                    nv = 1'b1;
                    no = {id, e};
                end
                acc = bus.send_req && (sz < FD);
`ifdef TX_DROP_SELF_EN
                if (bus.send_dest == id) acc = 1'b0;
`endif
                if (acc) m_q.push_back({bus.send_data, bus.send_dest});
                m_slot  = (m_slot + 1) % NN;
                m_valid = nv;
                m_out   = no;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("tx_valid",   32'(bus.tx_valid),   32'(m_valid));
                chk("tx_out",     32'(bus.tx_out),     32'(m_out));
                chk("slot_cnt",   32'(slot_cnt),       32'(m_slot));
                chk("fifo_count", 32'(fifo_count),     32'(m_q.size()));
                chk("send_ready", 32'(bus.send_ready), 32'(m_q.size() < FD));
            end
        end
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic wait_slot(input int s);
        for (int k = 0; k < 8 && int'(slot_cnt) != s; k++) @(negedge clk);
        if (int'(slot_cnt) != s) chk("wait_slot_timeout", 32'(slot_cnt), 32'(s));
    endtask

    task automatic drive(input logic [IW-1:0] d, input logic [DW-1:0] dat);
        bus.send_req  = 1'b1;
        bus.send_dest = d;
        bus.send_data = dat;
        @(negedge clk);
        bus.send_req  = 1'b0;
        $display("request dest=%0d data=0x%02h", d, dat);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "simulation timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int         slot_seq[4];
        int         got_n;
        logic [7:0] got_d[4];
        int         got_c[4];
        int         lat;

        slot_seq = '{1, 2, 3, 0};
        bus.send_req = 1'b0; bus.send_dest = '0; bus.send_data = '0;

        // Reset for two cycles
        rst = 1'b1;
        @(posedge clk); cmp_en = 1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
        chk("rst_tx_out",     32'(bus.tx_out),     32'd0);
        chk("rst_slot_cnt",   32'(slot_cnt),       32'd0);
        chk("rst_fifo_count", 32'(fifo_count),     32'd0);
        chk("rst_send_ready", 32'(bus.send_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("slot_seq", 32'(slot_cnt), 32'(slot_seq[i]));
        end

        // Single send: enqueue in slot 1, packet appears the cycle after slot 2
        wait_slot(1);
        drive(2'd1, 8'hA5);
        @(negedge clk);
        chk("single_valid", 32'(bus.tx_valid), 32'd1);
        chk("single_out",   32'(bus.tx_out),   32'hA95);
        $display("tx packet 0x%03h", bus.tx_out);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("single_quiet", 32'(bus.tx_valid), 32'd0);
        end
        chk("single_drained", 32'(fifo_count), 32'd0);

        // Fill and order; 5th request lands in the grant cycle while full
        wait_slot(2);
        for (int i = 1; i <= 4; i++) drive(2'(i - 1), 8'(i));
        chk("full_ready", 32'(bus.send_ready), 32'd0);
        chk("full_count", 32'(fifo_count),     32'd4);
        drive(2'd0, 8'h05);
        chk("full_pop_count", 32'(fifo_count), 32'd3);
        got_n = 0;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.tx_valid && got_n < 4) begin
                got_d[got_n] = bus.tx_out[9:2];
                got_c[got_n] = c;
                $display("tx packet 0x%03h at +%0d", bus.tx_out, c);
                got_n++;
            end
        end
        chk("order_count", 32'(got_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_n) begin
                chk("order_data",  32'(got_d[k]), 32'(k + 1));
                chk("order_cycle", 32'(got_c[k]), 32'(4 * k));
            end
        end

        // Late arrival: push into empty queue during the owned slot
        wait_slot(2);
        drive(2'd3, 8'h5A);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            if (bus.tx_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("late_latency", 32'(lat),        32'd5);
        chk("late_out",     32'(bus.tx_out), 32'h96B);
        $display("tx packet 0x%03h latency %0d", bus.tx_out, lat);

        // Push with pop in the same cycle, not full
        wait_slot(0);
        drive(2'd0, 8'h11);
        drive(2'd1, 8'h22);
        drive(2'd3, 8'h33);
        chk("pushpop_count", 32'(fifo_count), 32'd2);
        chk("pushpop_out",   32'(bus.tx_out), 32'h844);
        repeat (10) @(negedge clk);

        // Reset in a grant cycle with two entries pending
        wait_slot(3);
        drive(2'd0, 8'h44);
        drive(2'd1, 8'h55);
        @(negedge clk);
        chk("prerst_count", 32'(fifo_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_count",    32'(fifo_count),   32'd0);
        chk("midrst_slot",     32'(slot_cnt),     32'd0);
        rst = 1'b0;

        // Self-addressed request
        drive(2'd2, 8'h66);
`ifdef TX_DROP_SELF_EN
        chk("self_count", 32'(fifo_count), 32'd0);
`else
        chk("self_count", 32'(fifo_count), 32'd1);
`endif
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
